// File: rtl/hex_display_driver_if.sv
// CPU-facing bundle of the hex display driver: value/load from the gpio_out
// write path, multiplexed segment/anode drive and status back.
interface hex_display_driver_if;
    logic [31:0] value;
    logic        load;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic        frame_done;
    logic        pending;

    modport master (
        output value, load,
        input  seg_n, dp_n, an_n, frame_done, pending
    );

    modport slave (
        input  value, load,
        output seg_n, dp_n, an_n, frame_done, pending
    );
endinterface

// File: rtl/hex_display_driver.sv
// 8-digit multiplexed 7-segment driver with a tear-free shadow register and
// anti-ghost blanking. Optional macro LEADING_ZERO_BLANK_EN hides leading zeros.
module hex_display_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 4
) (
    input logic                  clk,
    input logic                  rst,
    hex_display_driver_if.slave  bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc_q;
    logic [2:0]    idx_q;
    logic [31:0]   disp_q;
    logic [31:0]   pend_q;
    logic          pending_q;
    logic          frame_done_q;
    logic [7:0]    an_n_q, an_n_d;
    logic [6:0]    seg_n_q, seg_n_d;

    logic          tick;
    logic          wrap;
    logic          blank;
    logic          digit_on;
    logic [3:0]    nibble;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Highest nonzero nibble; 0 when the word is zero so digit 0 always shows.
    function automatic logic [2:0] top_digit(input logic [31:0] w);
        logic [2:0] t;
        t = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (w[4*i +: 4] != 4'h0) t = 3'(i);
        end
        return t;
    endfunction
`endif

    assign tick   = (presc_q == PW'(SCAN_DIV - 1));
    assign wrap   = tick && (idx_q == 3'd7);
    assign blank  = (presc_q < PW'(BLANK_CYC));
    assign nibble = disp_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    assign digit_on = (idx_q <= top_digit(disp_q));
`else
    assign digit_on = 1'b1;
`endif

    always_comb begin
        an_n_d  = (blank || !digit_on) ? 8'hFF : ~(8'h01 << idx_q);
        seg_n_d = hex_glyph(nibble);
    end

    // disp only moves at the frame wrap, so a frame never mixes two values;
    // a load in the wrap cycle lands in pend after the old pend is committed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            idx_q        <= 3'd0;
            disp_q       <= 32'h0;
            pend_q       <= 32'h0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            an_n_q       <= 8'hFF;
            seg_n_q      <= 7'h7F;
        end else begin
            presc_q      <= tick ? '0 : presc_q + PW'(1);
            if (tick) idx_q <= idx_q + 3'd1;
            frame_done_q <= wrap;
            if (wrap && pending_q) disp_q <= pend_q;
            if (bus.load) pend_q <= bus.value;
            if (bus.load)      pending_q <= 1'b1;
            else if (wrap)     pending_q <= 1'b0;
            an_n_q       <= an_n_d;
            seg_n_q      <= seg_n_d;
        end
    end

    assign bus.seg_n      = seg_n_q;
    assign bus.an_n       = an_n_q;
    assign bus.dp_n       = 1'b1;
    assign bus.frame_done = frame_done_q;
    assign bus.pending    = pending_q;
endmodule

// File: tb/tb_hex_display_driver.sv
// Scoreboard bench for hex_display_driver at SCAN_DIV=8, BLANK_CYC=2: expected
// display words are queued per frame and checked by a frame-level monitor.
module tb_hex_display_driver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hex_display_driver_if bus();

    hex_display_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic bit digit_shown(input logic [31:0] w, input int d);
        if (!LZB || d == 0) return 1'b1;
        return (w >> (4 * d)) != 32'h0;
    endfunction

    // Frame monitor: one frame = 64 output samples ending on the frame_done sample.
    logic [6:0] seen_seg [8];
    int         seen_cnt [8];
    bit         unstable [8];
    int         bad_an;
    int         bad_dp;
    int         spacing;

    task automatic clear_frame();
        for (int d = 0; d < 8; d++) begin
            seen_seg[d] = 7'h0;
            seen_cnt[d] = 0;
            unstable[d] = 1'b0;
        end
        bad_an = 0;
        bad_dp = 0;
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        logic [7:0]  m;
        bit          found;
        if (rst) begin
            clear_frame();
            spacing = 0;
        end else begin
            spacing++;
            if (bus.dp_n !== 1'b1) bad_dp++;
            if (bus.an_n !== 8'hFF) begin
                found = 1'b0;
                for (int d = 0; d < 8; d++) begin
                    m = ~(8'h01 << d);
                    if (bus.an_n === m) begin
                        if (seen_cnt[d] == 0) seen_seg[d] = bus.seg_n;
                        else if (seen_seg[d] !== bus.seg_n) unstable[d] = 1'b1;
                        seen_cnt[d]++;
                        found = 1'b1;
                    end
                end
                if (!found) bad_an++;
            end
            if (bus.frame_done === 1'b1) begin
                check("frame_period", 64'(spacing), 64'd64);
                check("an_n_onehot", 64'(bad_an), 64'd0);
                check("dp_n_high", 64'(bad_dp), 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: frame ended with no expected value queued");
                end else begin
                    e = exp_q.pop_front();
                    for (int d = 0; d < 8; d++) begin
                        bit sh;
                        sh = digit_shown(e, d);
                        check($sformatf("digit%0d_of_%08h {cnt,seg,unstable}", d, e),
                              {32'(seen_cnt[d]), 24'h0, seen_seg[d], unstable[d]},
                              {32'(sh ? 6 : 0), 24'h0, (sh ? glyph(4'((e >> (4 * d)) & 32'hF)) : 7'h0), 1'b0});
                    end
                end
                clear_frame();
                spacing = 0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] v);
        bus.value = v;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_done !== 1'b1 && n < 200);
        if (bus.frame_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_done not seen within 200 cycles", tag);
        end
    endtask

    initial begin
        bus.value = 32'h0;
        bus.load  = 1'b0;
        #2 rst = 1'b1;
        idle(2);
        check("rst_an_n", bus.an_n, 8'hFF);
        check("rst_seg_n", bus.seg_n, 7'h7F);
        check("rst_dp_n", bus.dp_n, 1'b1);
        check("rst_frame_done", bus.frame_done, 1'b0);
        check("rst_pending", bus.pending, 1'b0);

        // Blank display after reset: every digit shows 0.
        exp_q.push_back(32'h0);
        #2 rst = 1'b0;
        wait_frame("frame0");

        // Load mid-frame at digit 3: visible only from the next frame.
        exp_q.push_back(32'h0);
        idle(24);
        do_load(32'h1234_5678);
        check("pending_after_load", bus.pending, 1'b1);
        wait_frame("frame1");
        check("pending_cleared_at_wrap", bus.pending, 1'b0);

        // Two loads in one frame: last one wins, the first never appears.
        exp_q.push_back(32'h1234_5678);
        idle(8);
        do_load(32'hAAAA_0000);
        idle(7);
        do_load(32'h0000_BEEF);
        wait_frame("frame2");
        exp_q.push_back(32'h0000_BEEF);
        wait_frame("frame3");

        // Load coinciding with the wrap: old pend commits, new one stays pending.
        exp_q.push_back(32'h0000_BEEF);
        idle(8);
        do_load(32'h0000_0002);
        idle(54);
        bus.value = 32'h0000_0001;
        bus.load  = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        check("wrap_cycle_alignment", bus.frame_done, 1'b1);
        check("pending_held_over_wrap", bus.pending, 1'b1);
        exp_q.push_back(32'h0000_0002);
        wait_frame("frame5");
        check("pending_cleared_after_second_wrap", bus.pending, 1'b0);
        exp_q.push_back(32'h0000_0001);
        idle(8);
        do_load(32'h0000_00F0);
        wait_frame("frame6");
        exp_q.push_back(32'h0000_00F0);
        wait_frame("frame7");

        // Asynchronous reset at digit 5 with a load pending.
        exp_q.push_back(32'h0000_00F0);
        idle(8);
        do_load(32'h0000_0055);
        idle(34);
        #2 rst = 1'b1;
        #1;
        check("async_rst_an_n", bus.an_n, 8'hFF);
        check("async_rst_seg_n", bus.seg_n, 7'h7F);
        check("async_rst_frame_done", bus.frame_done, 1'b0);
        check("async_rst_pending", bus.pending, 1'b0);
        exp_q.delete();
        idle(2);
        exp_q.push_back(32'h0);
        #2 rst = 1'b0;
        wait_frame("frame_after_rst");
        check("pending_after_rst", bus.pending, 1'b0);

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
